// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor with valid/ready handshakes
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;
    logic             br;
    logic             br_next;
    logic             g;
    logic             p;
    logic             di;
    logic             last;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    // Borrow generate/propagate on the current LSB of the operand shifters
    assign g       = ~a_sh[0] & b_sh[0];
    assign p       = ~(a_sh[0] ^ b_sh[0]);
    assign di      = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = g | (p & br);
    assign d_next  = {di, d_sh[WIDTH-1:1]};
    assign last    = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Result lives in a separate working shifter so visible outputs hold during RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            d_sh        <= '0;
            diff_q      <= '0;
            cnt         <= '0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            br          <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        d_sh  <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= bin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_next;
                    br   <= br_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        diff_q      <= d_next;
                        bout_q      <= br_next;
                        ovf_q       <= (a_msb != b_msb) && (d_next[WIDTH-1] != a_msb);
                        zero_q      <= (d_next == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference model: wide arithmetic for borrow, signed integers for overflow
    task automatic push_expected(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        exp_t        e;
        logic [W:0]  wide;
        int          sres;
        wide   = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        sres   = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
        e.diff = wide[W-1:0];
        e.bout = wide[W];
        e.ovf  = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
        e.zero = (wide[W-1:0] == '0);
        exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input int stall);
        exp_t         e;
        int           cyc;
        logic [W-1:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        push_expected(ta, tb, tbin);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL accept_busy: in_ready=%b required 0", in_ready);
        end
        cyc = 0;
        while (cyc < W + 5) begin
            @(posedge clk); #1; cyc++;
            if (out_valid) break;
        end
        n_checks++;
        if (cyc !== W || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL latency: cycles=%0d out_valid=%b required %0d/1", cyc, out_valid, W);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (diff !== e.diff || bout !== e.bout || ovf !== e.ovf || zero !== e.zero) begin
            n_fail++;
            $display("FAIL result a=%h b=%h bin=%b: diff=%h bout=%b ovf=%b zero=%b required %h %b %b %b",
                     ta, tb, tbin, diff, bout, ovf, zero, e.diff, e.bout, e.ovf, e.zero);
        end
        held = diff;
        for (int i = 0; i < stall; i++) begin
            a = ~ta; b = ~tb; in_valid = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || diff !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: out_valid=%b diff=%h in_ready=%b required 1 %h 0",
                         out_valid, diff, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 ||
            bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h flags=%b%b%b required 1 0 00 000",
                     in_ready, out_valid, diff, bout, ovf, zero);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_no_capture: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        run_op(8'h05, 8'h03, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 0);
    endtask

    task automatic test_overflow;
        run_op(8'h80, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_borrow_zero;
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'h42, 8'h42, 1'b0, 0);
        run_op(8'h42, 8'h41, 1'b1, 0);
    endtask

    task automatic test_backpressure;
        run_op(8'hA5, 8'h3C, 1'b1, 5);
    endtask

    task automatic test_abort;
        int seen;
        a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0 || in_ready !== 1'b1 || diff !== 8'h00) begin
            n_fail++;
            $display("FAIL abort: out_valid_cycles=%0d in_ready=%b diff=%h required 0 1 00",
                     seen, in_ready, diff);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_borrow_zero();
        test_backpressure();
        test_abort();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
